// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the 2-input gate sweep checker.
package gate_sweep_pkg;

  // Sweep sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of input vectors applied to a 2-input gate
  localparam int NUM_VECTORS = 4;

  // Truth tables, bit i = output for vector i = {in0,in1}
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_sweep_checker_settle_counter.sv
// Loadable down-counter used to time the settle interval of each vector.
module settle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Load has priority; decrement stops at zero so the count never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps the four input vectors of a 2-input gate, samples its output after
// a settle interval and compares the captured table against EXPECTED.
// All outputs are registered from the sequencer state, so they trail the
// state by one cycle.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 10,
  parameter logic [3:0] EXPECTED      = TT_NAND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in0,
  output logic       in1,
  output logic       busy,
  output logic       done,
  output logic [3:0] captured,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic       pass
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_r;
  state_t     state_s;
  logic [1:0] idx_r;
  logic       cnt_load_s;
  logic       cnt_en_s;
  logic       cnt_zero_s;
  logic       clear_s;
  logic       abort_s;
  logic       sample_s;
  logic       active_s;

  settle_counter #(.WIDTH(8)) u_settle_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load_s),
    .enable     (cnt_en_s),
    .load_value (SETTLE_LOAD),
    .zero       (cnt_zero_s)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_s    = state_r;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    clear_s    = 1'b0;
    abort_s    = 1'b0;
    sample_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = SETTLE;
          cnt_load_s = 1'b1;
          clear_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else if (cnt_zero_s) begin
          state_s = SAMPLE;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          sample_s = 1'b1;
          if (idx_r == 2'd3) begin
            state_s = DONE;
          end else begin
            state_s    = SETTLE;
            cnt_load_s = 1'b1;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign active_s = (state_r == SETTLE) || (state_r == SAMPLE);

  // Vector index, result capture and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r      <= 2'd0;
      in0        <= 1'b0;
      in1        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      captured   <= 4'd0;
      err_count  <= 3'd0;
      first_fail <= 2'd0;
      pass       <= 1'b0;
    end else begin
      in0  <= active_s ? idx_r[1] : 1'b0;
      in1  <= active_s ? idx_r[0] : 1'b0;
      busy <= active_s;
      done <= (state_r == DONE);
      if (clear_s) begin
        idx_r      <= 2'd0;
        captured   <= 4'd0;
        err_count  <= 3'd0;
        first_fail <= 2'd0;
        pass       <= 1'b0;
      end else if (abort_s) begin
        idx_r     <= 2'd0;
        captured  <= 4'd0;
        err_count <= 3'd0;
        pass      <= 1'b0;
      end else if (sample_s) begin
        captured[idx_r] <= dut_out;
        if (dut_out != EXPECTED[idx_r]) begin
          err_count <= err_count + 3'd1;
          if (err_count == 3'd0) begin
            first_fail <= idx_r;
          end
        end
        if (idx_r != 2'd3) begin
          idx_r <= idx_r + 2'd1;
        end
      end else if (state_r == DONE) begin
        // err_count already includes the last vector's sample here
        pass <= (err_count == 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized self-checking bench for gate_sweep_checker. Two instances share
// the clock and reset: one at the default settle interval, one with a single
// settle cycle. Each drives a behavioural gate defined by a truth table.
module tb_gate_sweep_checker;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, abort_a, in0_a, in1_a, busy_a, done_a, pass_a, dut_out_a;
  logic [3:0] captured_a;
  logic [2:0] err_a;
  logic [1:0] ff_a;
  logic       start_b, abort_b, in0_b, in1_b, busy_b, done_b, pass_b, dut_out_b;
  logic [3:0] captured_b;
  logic [2:0] err_b;
  logic [1:0] ff_b;
  logic [3:0] tt_a, tt_b;

  // Behavioural gates under test
  assign dut_out_a = tt_a[{in0_a, in1_a}];
  assign dut_out_b = tt_b[{in0_b, in1_b}];

  gate_sweep_checker #(.SETTLE_CYCLES(10), .EXPECTED(TT_NAND)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
    .in0(in0_a), .in1(in1_a), .busy(busy_a), .done(done_a), .captured(captured_a),
    .err_count(err_a), .first_fail(ff_a), .pass(pass_a));

  gate_sweep_checker #(.SETTLE_CYCLES(1), .EXPECTED(TT_NAND)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_out(dut_out_b),
    .in0(in0_b), .in1(in1_b), .busy(busy_b), .done(done_b), .captured(captured_b),
    .err_count(err_b), .first_fail(ff_b), .pass(pass_b));

  // Selected instance view
  logic       sel;
  logic       o_in0, o_in1, o_busy, o_done, o_pass;
  logic [3:0] o_cap;
  logic [2:0] o_err;
  logic [1:0] o_ff;
  assign o_in0  = sel ? in0_b : in0_a;
  assign o_in1  = sel ? in1_b : in1_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;
  assign o_cap  = sel ? captured_b : captured_a;
  assign o_err  = sel ? err_b : err_a;
  assign o_ff   = sel ? ff_b : ff_a;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int settle_of();
    return sel ? 1 : 10;
  endfunction

  function automatic int sweep_len();
    return 4 * (settle_of() + 1);
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_abort(input logic v);
    if (sel) abort_b = v; else abort_a = v;
  endtask

  task automatic set_gate(input logic [3:0] tt);
    if (sel) tt_b = tt; else tt_a = tt;
  endtask

  // Reference: what a sweep of a gate with table tt must report
  task automatic model(input logic [3:0] tt, output int err, output int ff);
    logic [3:0] exp_tt;
    exp_tt = TT_NAND;
    err = 0;
    ff = 0;
    for (int v = 0; v < NUM_VECTORS; v++) begin
      if (tt[v] != exp_tt[v]) begin
        if (err == 0) ff = v;
        err++;
      end
    end
  endtask

  // One full sweep; optionally pulses start again at cycle glitch_n (ignored)
  task automatic run_sweep(input logic [3:0] tt, input int glitch_n);
    int n, bad, err, ff, len, v;
    logic eb;
    len = sweep_len();
    set_gate(tt);
    model(tt, err, ff);
    set_start(1'b1);
    tick();
    n = 0;
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      set_start((glitch_n > 0 && n == glitch_n) ? 1'b1 : 1'b0);
      tick();
      n = k;
      if (n >= 1 && n <= len) begin
        v = (n - 1) / (settle_of() + 1);
        eb = 1'b1;
      end else begin
        v = 0;
        eb = 1'b0;
      end
      if ({o_in0, o_in1} !== 2'(v) || o_busy !== eb) bad++;
      if (o_done === 1'b1) break;
    end
    set_start(1'b0);
    check_value("done_latency", n, len + 1);
    check_value("vector_trace_errors", bad, 0);
    check_value("captured", o_cap, tt);
    check_value("err_count", o_err, err);
    if (err != 0) check_value("first_fail", o_ff, ff);
    check_value("pass", o_pass, (err == 0) ? 1 : 0);
    tick();
    check_value("done_one_cycle", o_done, 0);
    check_value("captured_held", o_cap, tt);
  endtask

  // Sweep interrupted by abort or reset sampled at cycle at_n after start
  task automatic run_interrupt(input logic [3:0] tt, input int at_n, input logic use_reset);
    int dones;
    set_gate(tt);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int k = 1; k < at_n; k++) tick();
    if (use_reset) rst_n = 1'b0; else set_abort(1'b1);
    tick();
    rst_n = 1'b1;
    set_abort(1'b0);
    if (use_reset) begin
      check_value("rst_outputs", {o_in0, o_in1, o_busy, o_done, o_pass, o_cap, o_err, o_ff}, 0);
    end else begin
      tick();
      check_value("abort_busy", o_busy, 0);
      check_value("abort_inputs", {o_in0, o_in1}, 0);
      check_value("abort_results", {o_cap, o_err, o_pass}, 0);
    end
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (o_done === 1'b1) dones++;
    end
    check_value(use_reset ? "rst_no_done" : "abort_no_done", dones, 0);
  endtask

  // start held high: back-to-back sweeps
  task automatic run_hold();
    int t[3];
    int got;
    logic p[3];
    set_gate(TT_NAND);
    set_start(1'b1);
    got = 0;
    for (int k = 0; k < 400 && got < 3; k++) begin
      tick();
      if (o_done === 1'b1) begin
        t[got] = k;
        p[got] = o_pass;
        got++;
      end
    end
    set_start(1'b0);
    check_value("hold_done_count", got, 3);
    if (got == 3) begin
      check_value("hold_spacing_0", t[1] - t[0], sweep_len() + 2);
      check_value("hold_spacing_1", t[2] - t[1], sweep_len() + 2);
      check_value("hold_pass", {p[0], p[1], p[2]}, 3'b111);
    end
    for (int k = 0; k < 3; k++) tick();
  endtask

  initial begin
    logic [3:0] tt;
    sel = 1'b0;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    tt_a = TT_NAND; tt_b = TT_NAND;
    tick();
    tick();
    check_value("reset_a", {in0_a, in1_a, busy_a, done_a, pass_a, captured_a, err_a, ff_a}, 0);
    check_value("reset_b", {in0_b, in1_b, busy_b, done_b, pass_b, captured_b, err_b, ff_b}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    run_sweep(TT_NAND, 0);
    run_sweep(TT_AND, 0);
    sel = 1'b1;
    run_sweep(4'b1111, 0);
    sel = 1'b0;
    run_interrupt(TT_NAND, 2 * 11 + 3, 1'b0);
    run_sweep(TT_NAND, 0);
    run_interrupt(TT_NAND, 2 * 11, 1'b1);
    run_sweep(TT_NAND, 20);
    run_hold();
    sel = 1'b1;
    run_hold();

    for (int r = 0; r < 10; r++) begin
      sel = 1'($urandom_range(0, 1));
      tt = 4'($urandom_range(0, 15));
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) tick();
      run_sweep(tt, int'($urandom_range(0, sweep_len() - 1)));
    end
    for (int r = 0; r < 4; r++) begin
      sel = 1'($urandom_range(0, 1));
      run_interrupt(4'($urandom_range(0, 15)), int'($urandom_range(1, sweep_len())), 1'b0);
      run_sweep(TT_XOR, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Hardware counterpart of the gate-level simulation benches: a synthesizable block that drives the four input vectors of any 2-input gate under test and captures its response.
- Applies in0/in1 in order 00, 01, 10, 11, waits a settle interval per vector, samples the gate output and compares it against an expected truth table.
- Reports the captured table, the mismatch count and a pass flag, so pj-level gates can be checked on-chip or in a clocked bench without hand-written delays.

Parameters:
- SETTLE_CYCLES, 10: cycles each vector is held before sampling; legal range 1..255.
- EXPECTED, 4'b0111: expected truth table, bit i = expected out for vector i = {in0,in1}. The default is NAND.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  cancel a sweep in progress; synchronous
- dut_out  in  1  output of the gate under test
- in0  out  1  gate input 0 (MSB of vector index)
- in1  out  1  gate input 1 (LSB of vector index)
- busy  out  1  high from SETTLE through SAMPLE of the last vector
- done  out  1  one-cycle pulse when a sweep completes
- captured  out  4  sampled truth table, bit i = dut_out for vector i
- err_count  out  3  number of mismatching vectors, 0..4
- first_fail  out  2  index of the first mismatching vector; valid when err_count != 0
- pass  out  1  high when the last completed sweep had err_count == 0

Behaviour:
- Reset: one clock, synchronous and active-low.
  - While rst_n == 0 at a rising edge, the state goes to IDLE.
  - in0, in1, busy, done, captured, err_count, first_fail and pass are all forced to 0.
  - Reset wins over start and abort in the same cycle, and it aborts a sweep mid-operation.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - in0 = in1 = 0.
  - Results from the previous sweep are held.
  - When start == 1: clear captured, err_count, first_fail and pass; set vector idx = 0 and counter = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - {in0,in1} = idx.
  - The counter decrements each cycle; when counter == 0, go to SAMPLE. The state therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle, inputs still = idx):
  - captured[idx] <= dut_out.
  - If dut_out != EXPECTED[idx]: err_count increments; first_fail <= idx if err_count was 0.
  - If idx == 3, go to DONE. Otherwise idx++, reload the counter and go to SETTLE.
- DONE (one cycle):
  - done = 1 and pass = (err_count == 0), using the final count including the last sample.
  - Go to IDLE. Inputs return to 00 on the next cycle.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - If start is sampled at edge T, done is high in cycle T + 4*(SETTLE_CYCLES+1) + 1 (T+45 at the default).
- Start handling: start is ignored in SETTLE, SAMPLE and DONE; there is no queuing. start held high re-triggers a new sweep from IDLE.
- abort:
  - In SETTLE or SAMPLE: go to IDLE next cycle with no done pulse; captured, err_count and pass are cleared to 0.
  - In IDLE or DONE: no effect.
  - abort and start together in IDLE: start wins.
- Width rules:
  - err_count saturates naturally at 4, since it cannot exceed 4.
  - The counter width is 8 bits; SETTLE_CYCLES = 1 gives a single settle cycle.

Decomposition:
- Package gate_sweep_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VECTORS = 4;
  - truth-table constants TT_NAND = 4'b0111, TT_AND = 4'b1000, TT_OR = 4'b1110, TT_XOR = 4'b0110.
- One sub-module, settle_counter: a loadable down-counter with load, enable and a zero flag, parameterized width.

Test Plan:
1. NAND gate attached, defaults, start pulse at cycle 5 -> in0/in1 step 00, 01, 10, 11 every 11 cycles; done at cycle 50; captured=0111, err_count=0, pass=1.
2. Inverted-output fault (dut_out = AND) with EXPECTED=TT_NAND -> captured=1000, err_count=4, first_fail=0, pass=0.
3. Stuck-at-1 output, SETTLE_CYCLES=1 -> captured=1111, err_count=1, first_fail=3; done 9 cycles after start.
4. abort asserted 3 cycles into vector 2 -> busy falls the next cycle, no done pulse, in0=in1=0, err_count=0, pass=0; a following start completes normally.
5. rst_n low for one cycle during SAMPLE of vector 1 -> all outputs 0 next cycle and state IDLE; start during busy is ignored (done still at T+45 from the original start).
6. start held high continuously with a NAND gate attached -> back-to-back sweeps, each done spaced 46 cycles apart, pass=1 each time.
